machine_timer: RTL and testbench

- Memory-mapped machine timer. It is the interrupt source that sits directly upstream of the core-local interrupt arbiter.
- Holds a 64-bit free-running mtime counter with a programmable prescaler and a 64-bit mtimecmp.
- Raises a level-sensitive timer interrupt on the core interrupt bus. That bus feeds the arbiter's interrupt-flag input.
- Slave on the system bus: 32-bit accesses with a registered, one-cycle read/write acknowledge.

---
 rtl/machine_timer_pkg.sv | 35 +++
 rtl/machine_timer_if.sv | 12 +
 rtl/machine_timer_prescaler.sv | 24 ++
 rtl/machine_timer.sv | 118 +++++++++++
 tb/tb_machine_timer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/machine_timer_pkg.sv
// rtl/machine_timer_pkg.sv - shared offsets, CTRL layout and constants for the machine timer
package machine_timer_pkg;

  // Word offsets as seen on addr[5:2]
  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_MTIME_LO = 4'h1;
  localparam logic [3:0] OFF_MTIME_HI = 4'h2;
  localparam logic [3:0] OFF_CMP_LO   = 4'h3;
  localparam logic [3:0] OFF_CMP_HI   = 4'h4;

  // CTRL bit positions
  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_IE        = 1;
  localparam int unsigned CTRL_PEND      = 2;
  localparam int unsigned CTRL_PRESC_LSB = 8;

  // Timer line position on the interrupt bus
  localparam int unsigned INT_TIMER = 0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  // Pack the CTRL read value; unused bits read as zero
  function automatic logic [31:0] ctrl_word(input logic en, input logic ie,
                                            input logic pend, input logic [7:0] presc);
    logic [31:0] w;
    w = ZERO_WORD;
    w[CTRL_EN]               = en;
    w[CTRL_IE]               = ie;
    w[CTRL_PEND]             = pend;
    w[CTRL_PRESC_LSB +: 8]   = presc;
    return w;
  endfunction

endpackage

// File: rtl/machine_timer_if.sv
// rtl/machine_timer_if.sv - system bus slave port of the machine timer
interface machine_timer_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (output req_i, we_i, addr_i, data_i, input data_o, ack_o);
  modport slave  (input req_i, we_i, addr_i, data_i, output data_o, ack_o);
endinterface

// File: rtl/machine_timer_prescaler.sv
// rtl/machine_timer_prescaler.sv - prescale counter producing the mtime increment tick
module machine_timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       tick
);
  logic [7:0] presc_cnt;

  assign tick = en && (presc_cnt == prescale);

  // Count up while enabled, restart on reaching prescale or on a CTRL write; hold when disabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_cnt <= '0;
    end else if (clr) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
    end
  end
endmodule

// File: rtl/machine_timer.sv
// rtl/machine_timer.sv - memory-mapped 64-bit machine timer with compare interrupt
module machine_timer
  import machine_timer_pkg::*;
#(
  parameter int unsigned INT_W     = 8,
  parameter logic [31:0] BASE_MASK = 32'h0000_003F
) (
  input  logic             clk,
  input  logic             rst,
  machine_timer_if.slave   bus,
  output logic [INT_W-1:0] int_sig_o
);
  logic [3:0]  off;
  logic        wr, rd;
  logic        ctrl_wr, lo_wr, hi_wr, cmp_lo_wr, cmp_hi_wr, lo_rd;
  logic        ctrl_en, ctrl_ie, pending;
  logic [7:0]  prescale;
  logic [63:0] mtime, mtimecmp;
  logic [31:0] hi_shadow, rdata, rdata_q;
  logic        ack_q, tick, match;

  assign off       = 4'((bus.addr_i & BASE_MASK) >> 2);
  assign wr        = bus.req_i && bus.we_i;
  assign rd        = bus.req_i && !bus.we_i;
  assign ctrl_wr   = wr && (off == OFF_CTRL);
  assign lo_wr     = wr && (off == OFF_MTIME_LO);
  assign hi_wr     = wr && (off == OFF_MTIME_HI);
  assign cmp_lo_wr = wr && (off == OFF_CMP_LO);
  assign cmp_hi_wr = wr && (off == OFF_CMP_HI);
  assign lo_rd     = rd && (off == OFF_MTIME_LO);
  assign match     = (mtime >= mtimecmp);

  machine_timer_prescaler u_presc (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_en),
    .clr      (ctrl_wr),
    .prescale (prescale),
    .tick     (tick)
  );

  // Read mux for the register map; unmapped offsets read zero
  always_comb begin
    rdata = ZERO_WORD;
    case (off)
      OFF_CTRL:     rdata = ctrl_word(ctrl_en, ctrl_ie, pending, prescale);
      OFF_MTIME_LO: rdata = mtime[31:0];
      OFF_MTIME_HI: rdata = hi_shadow;
      OFF_CMP_LO:   rdata = mtimecmp[31:0];
      OFF_CMP_HI:   rdata = mtimecmp[63:32];
      default:      rdata = ZERO_WORD;
    endcase
  end

  // CTRL fields; a pending set from match wins over a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en  <= 1'b0;
      ctrl_ie  <= 1'b0;
      prescale <= '0;
      pending  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en  <= bus.data_i[CTRL_EN];
        ctrl_ie  <= bus.data_i[CTRL_IE];
        prescale <= bus.data_i[CTRL_PRESC_LSB +: 8];
      end
      pending <= match || (pending && !(ctrl_wr && bus.data_i[CTRL_PEND]));
    end
  end

  // mtime: a bus write to either half replaces that half and suppresses the tick for that cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime <= '0;
    end else if (lo_wr || hi_wr) begin
      if (lo_wr) mtime[31:0]  <= bus.data_i;
      if (hi_wr) mtime[63:32] <= bus.data_i;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp halves written independently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= CMP_RESET;
    end else begin
      if (cmp_lo_wr) mtimecmp[31:0]  <= bus.data_i;
      if (cmp_hi_wr) mtimecmp[63:32] <= bus.data_i;
    end
  end

  // Capture the upper half on a low-half read so LO-then-HI returns a consistent pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_shadow <= ZERO_WORD;
    end else if (lo_rd) begin
      hi_shadow <= mtime[63:32];
    end
  end

  // One-cycle registered acknowledge; data is zero except on a read acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      rdata_q <= ZERO_WORD;
    end else begin
      ack_q   <= bus.req_i;
      rdata_q <= rd ? rdata : ZERO_WORD;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdata_q;
  assign int_sig_o  = INT_W'(pending && ctrl_ie) << INT_TIMER;

endmodule

// File: tb/tb_machine_timer.sv
// tb/tb_machine_timer.sv - scoreboard bench for machine_timer with a reference model
module tb_machine_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] int_sig_o;

  machine_timer_if bus();

  machine_timer #(.INT_W(8), .BASE_MASK(32'h0000_003F)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .int_sig_o (int_sig_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [7:0]  exp_int = 8'h00;

  // Reference model: mtime is an anchor value plus the number of prescaler periods elapsed
  bit          m_en, m_ie, m_pend;
  int          m_p;
  longint      m_ph, m_acyc;
  logic [63:0] m_aval, m_cmp;
  logic [31:0] m_shadow;

  function automatic longint nticks(longint x);
    if (x <= m_ph) return 0;
    return (x - m_ph) / longint'(m_p + 1);
  endfunction

  function automatic logic [63:0] mt(longint c);
    if (!m_en) return m_aval;
    return m_aval + 64'(nticks(c) - nticks(m_acyc));
  endfunction

  function automatic bit tick_at(longint c);
    return m_en && (c >= m_ph) && (((c - m_ph) % longint'(m_p + 1)) == longint'(m_p));
  endfunction

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_pend = 0; m_p = 0;
    m_ph = 0; m_acyc = 0; m_aval = '0; m_cmp = '1; m_shadow = '0;
  endtask

  // One bus cycle: drive, predict the response, advance the model, wait for the edge
  task automatic step(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] cur;
    logic [3:0]  off;
    logic [31:0] rv;
    bit          nxt;
    exp_int     = {7'b0, m_ie & m_pend};
    bus.req_i   = req;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.data_i  = data;
    off = 4'((addr & 32'h3F) >> 2);
    cur = mt(cyc);
    nxt = (cur >= m_cmp) || (m_pend && !(req && we && off == 4'h0 && data[2]));
    if (req) begin
      if (!we) begin
        case (off)
          4'h0:    rv = {16'h0, 8'(m_p), 5'h0, m_pend, m_ie, m_en};
          4'h1:    rv = cur[31:0];
          4'h2:    rv = m_shadow;
          4'h3:    rv = m_cmp[31:0];
          4'h4:    rv = m_cmp[63:32];
          default: rv = 32'h0;
        endcase
        q.push_back('{cyc + 1, 1'b1, rv});
        if (off == 4'h1) m_shadow = cur[63:32];
      end else begin
        q.push_back('{cyc + 1, 1'b0, 32'h0});
        case (off)
          4'h0: begin
            m_aval = cur + 64'(tick_at(cyc));
            m_acyc = cyc + 1;
            m_ph   = cyc + 1;
            m_en   = data[0];
            m_ie   = data[1];
            m_p    = int'(data[15:8]);
          end
          4'h1: begin m_aval = {cur[63:32], data}; m_acyc = cyc + 1; end
          4'h2: begin m_aval = {data, cur[31:0]}; m_acyc = cyc + 1; end
          4'h3: m_cmp[31:0]  = data;
          4'h4: m_cmp[63:32] = data;
          default: ;
        endcase
      end
    end
    m_pend = nxt;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Asynchronous reset while an acknowledge is in flight; nothing may be acked afterwards
  task automatic do_reset();
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
    q.delete();
    model_reset();
    exp_int = 8'h00;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b1;
  endtask

  // Monitor: compare interrupt bus every cycle and pop an expectation on each acknowledge slot
  always @(negedge clk) begin
    total++;
    if (int_sig_o !== exp_int) begin
      bad++;
      $display("FAIL int_sig cyc=%0d got=%h want=%h", cyc, int_sig_o, exp_int);
    end
    if (q.size() != 0 && q[0].cyc == cyc) begin
      mon_e = q.pop_front();
      total++;
      if (bus.ack_o !== 1'b1) begin
        bad++;
        $display("FAIL ack_missing cyc=%0d got=%b want=1", cyc, bus.ack_o);
      end else if (mon_e.rd) begin
        total++;
        if (bus.data_o !== mon_e.data) begin
          bad++;
          $display("FAIL rdata cyc=%0d got=%h want=%h", cyc, bus.data_o, mon_e.data);
        end
      end
    end else begin
      total++;
      if (bus.ack_o !== 1'b0 || bus.data_o !== 32'h0) begin
        bad++;
        $display("FAIL idle_bus cyc=%0d got ack=%b data=%h want ack=0 data=0",
                 cyc, bus.ack_o, bus.data_o);
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int          k;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset values
    rd(32'h0C); rd(32'h10); rd(32'h00); rd(32'h04); rd(32'h08);

    // Count with prescale=3
    wr(32'h00, 32'h0000_0301);
    idle(40);
    rd(32'h04); rd(32'h08);
    for (int i = 0; i < 8; i++) begin
      rd(32'h04);
      idle($urandom_range(0, 3));
    end

    // Compare interrupt, W1C while matching, then move compare away and clear
    wr(32'h00, 32'h0);
    wr(32'h04, 32'h0); wr(32'h08, 32'h0); wr(32'h10, 32'h0); wr(32'h0C, 32'd20);
    wr(32'h00, 32'h0000_0003);
    idle(25);
    wr(32'h00, 32'h0000_0007);
    rd(32'h00);
    wr(32'h0C, 32'd1000);
    wr(32'h00, 32'h0000_0007);
    idle(3);
    rd(32'h00);

    // Atomic LO/HI read across the 32-bit carry
    wr(32'h00, 32'h0);
    wr(32'h08, 32'h0); wr(32'h04, 32'hFFFF_FFFE);
    wr(32'h00, 32'h0000_0001);
    rd(32'h04); rd(32'h08); rd(32'h04); rd(32'h08);

    // 64-bit wrap with compare at all-ones, interrupt enable off
    wr(32'h00, 32'h0);
    wr(32'h0C, 32'hFFFF_FFFF); wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h08, 32'hFFFF_FFFF); wr(32'h04, 32'hFFFF_FFFD);
    wr(32'h00, 32'h0000_0001);
    idle(5);
    rd(32'h04); rd(32'h08); rd(32'h00);
    wr(32'h00, 32'h0000_0005);

    // Write collision on a tick cycle
    wr(32'h00, 32'h0);
    wr(32'h08, 32'd7); wr(32'h04, 32'h0);
    wr(32'h00, 32'h0000_0001);
    idle(2);
    wr(32'h04, 32'd5);
    rd(32'h04); rd(32'h08);

    // Back-to-back random traffic including unmapped offsets and masked upper address bits
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: a = 32'h00;
        1: a = 32'h04;
        2: a = 32'h08;
        3: a = 32'h0C;
        4: a = 32'h10;
        5: a = 32'h3C;
        default: a = 32'($urandom_range(0, 15)) << 2;
      endcase
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FFC0);
      d = $urandom;
      case (a[5:2])
        4'h0: d[15:8] = 8'($urandom_range(0, 3));
        4'h1: d = $urandom_range(0, 150);
        4'h2: d = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
        4'h3: d = $urandom_range(0, 300);
        4'h4: d = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
        default: ;
      endcase
      if (i == 150) begin
        rd(32'h00);
        do_reset();
        rd(32'h0C); rd(32'h10); rd(32'h00);
      end
      if ($urandom_range(0, 9) == 0) idle(1);
      else step(1'b1, 1'($urandom_range(0, 1)), a, d);
    end

    // Reset asserted right as an acknowledge is due, then reset-value reads
    rd(32'h04);
    do_reset();
    idle(2);
    rd(32'h0C); rd(32'h10); rd(32'h00);
    idle(3);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
